// File: rtl/score_accumulator_if.sv
// Judge-to-score bundle: session control and hit strobes in,
// score/combo/session status out toward the score display.
interface score_accumulator_if;
   logic       game_start;
   logic       game_end;
   logic       hit_valid;
   logic [1:0] hit_grade;
   logic [6:0] score;
   logic [6:0] combo;
   logic [6:0] max_combo;
   logic       score_upd;
   logic       playing;
   logic       final_valid;

   modport master (
      output game_start, game_end, hit_valid, hit_grade,
      input  score, combo, max_combo,
      input  score_upd, playing, final_valid
   );

   modport slave (
      input  game_start, game_end, hit_valid, hit_grade,
      output score, combo, max_combo,
      output score_upd, playing, final_valid
   );
endinterface

// File: rtl/score_accumulator.sv
// Running score/combo accumulator with IDLE/PLAY/DONE session FSM.
// Optional combo bonus enabled by defining COMBO_BONUS_EN.
module score_accumulator #(
   parameter int unsigned PERFECT_PTS = 3,
   parameter int unsigned GOOD_PTS    = 1,
   parameter int unsigned COMBO_STEP  = 10,
   parameter int unsigned SCORE_MAX   = 127
) (
   input  logic         clk_sys,
   input  logic         resetn,
   score_accumulator_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [7:0] PERF_P = 8'(PERFECT_PTS);
   localparam logic [7:0] GOOD_P = 8'(GOOD_PTS);
   localparam logic [7:0] SMAX8  = 8'(SCORE_MAX);
   localparam logic [6:0] SMAX7  = 7'(SCORE_MAX);

   state_e     state_q, state_d;
   logic [6:0] score_q, score_d;
   logic [6:0] combo_q, combo_d;
   logic [6:0] max_q, max_d;
   logic       upd_q, upd_d;

   logic [6:0] combo_inc;
   logic [7:0] pts;
   logic [7:0] sum;
   logic       bonus;

   assign combo_inc = (combo_q == 7'd127) ? 7'd127
                                          : combo_q + 7'd1;

`ifdef COMBO_BONUS_EN
   assign bonus = (combo_inc % 7'(COMBO_STEP)) == 7'd0;
`else
   logic unused_step;
   assign unused_step = ^COMBO_STEP;
   assign bonus       = 1'b0;
`endif

   assign pts = (bus.hit_grade == 2'd2) ? PERF_P : GOOD_P;
   assign sum = {1'b0, score_q} + pts + {7'd0, bonus};

   always_comb begin
      state_d = state_q;
      score_d = score_q;
      combo_d = combo_q;
      max_d   = max_q;
      upd_d   = 1'b0;
      if (bus.game_start) begin
         // restart wins over end and swallows any same-cycle hit
         state_d = PLAY;
         score_d = 7'd0;
         combo_d = 7'd0;
         max_d   = 7'd0;
      end else if (state_q == PLAY) begin
         if (bus.hit_valid) begin
            unique case (bus.hit_grade)
               2'd0: combo_d = 7'd0;
               2'd1, 2'd2: begin
                  combo_d = combo_inc;
                  score_d = (sum > SMAX8) ? SMAX7 : sum[6:0];
                  upd_d   = (score_d != score_q);
                  max_d   = (combo_inc > max_q) ? combo_inc
                                                : max_q;
               end
               default: ;
            endcase
         end
         if (bus.game_end) state_d = DONE;
      end
   end

   always_ff @(posedge clk_sys or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         score_q <= 7'd0;
         combo_q <= 7'd0;
         max_q   <= 7'd0;
         upd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         score_q <= score_d;
         combo_q <= combo_d;
         max_q   <= max_d;
         upd_q   <= upd_d;
      end
   end

   assign bus.score       = score_q;
   assign bus.combo       = combo_q;
   assign bus.max_combo   = max_q;
   assign bus.score_upd   = upd_q;
   assign bus.playing     = (state_q == PLAY);
   assign bus.final_valid = (state_q == DONE);

endmodule

// File: tb/tb_score_accumulator.sv
// Scoreboard bench for score_accumulator: a reference model pushes
// expected outputs per driven cycle; scenario tasks pop and compare.
module tb_score_accumulator;

   logic clk_sys = 1'b0;
   logic resetn  = 1'b0;

   score_accumulator_if bus ();

   score_accumulator dut (
      .clk_sys (clk_sys),
      .resetn  (resetn),
      .bus     (bus)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      int score;
      int combo;
      int maxc;
      bit upd;
      bit play;
      bit fin;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   int m_score, m_combo, m_max;
   bit m_play, m_fin, m_upd;

   function automatic logic [23:0] obs();
      return {bus.score, bus.combo, bus.max_combo,
              bus.score_upd, bus.playing, bus.final_valid};
   endfunction

   function automatic logic [23:0] pack(input exp_t x);
      return {7'(x.score), 7'(x.combo), 7'(x.maxc),
              x.upd, x.play, x.fin};
   endfunction

   task automatic model_reset();
      m_score = 0; m_combo = 0; m_max = 0;
      m_play = 0; m_fin = 0; m_upd = 0;
      sb.delete();
   endtask

   task automatic drive(input bit s, input bit e,
                        input bit v, input int g);
      int nc, nx, b;
      bus.game_start = s;
      bus.game_end   = e;
      bus.hit_valid  = v;
      bus.hit_grade  = 2'(g);
      m_upd = 0;
      if (s) begin
         m_score = 0; m_combo = 0; m_max = 0;
         m_play = 1; m_fin = 0;
      end else if (m_play) begin
         if (v && g == 0) m_combo = 0;
         else if (v && (g == 1 || g == 2)) begin
            nc = (m_combo < 127) ? m_combo + 1 : 127;
            b  = 0;
`ifdef COMBO_BONUS_EN
            if (nc % 10 == 0) b = 1;
`endif
            nx = m_score + ((g == 2) ? 3 : 1) + b;
            if (nx > 127) nx = 127;
            m_upd   = (nx != m_score);
            m_score = nx;
            m_combo = nc;
            if (nc > m_max) m_max = nc;
         end
         if (e) begin m_play = 0; m_fin = 1; end
      end
      sb.push_back('{m_score, m_combo, m_max,
                     m_upd, m_play, m_fin});
      @(posedge clk_sys); #1;
      bus.game_start = 1'b0;
      bus.game_end   = 1'b0;
      bus.hit_valid  = 1'b0;
      bus.hit_grade  = 2'd0;
   endtask

   task automatic test_reset();
      n_chk++;
      if (obs() !== 24'd0)
         $display("FAIL reset: got %h want 000000", obs());
      else n_pass++;
   endtask

   task automatic test_perfect3();
      exp_t x;
      drive(1, 0, 0, 0);
      x = sb.pop_front();
      n_chk++;
      if (obs() !== pack(x))
         $display("FAIL p3_start: got %h want %h", obs(), pack(x));
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 1, 2);
         x = sb.pop_front();
         n_chk++;
         if (obs() !== pack(x) || bus.score !== 7'(3 * (i + 1))
             || bus.score_upd !== 1'b1)
            $display("FAIL p3_hit%0d: got %h want %h",
                     i, obs(), pack(x));
         else n_pass++;
      end
      n_chk++;
      if (bus.combo !== 7'd3)
         $display("FAIL p3_combo: got %0d want 3", bus.combo);
      else n_pass++;
   endtask

   task automatic test_good10();
      exp_t x;
      int   want;
`ifdef COMBO_BONUS_EN
      want = 11;
`else
      want = 10;
`endif
      drive(1, 0, 0, 0);
      void'(sb.pop_front());
      for (int i = 0; i < 10; i++) begin
         drive(0, 0, 1, 1);
         x = sb.pop_front();
         n_chk++;
         if (obs() !== pack(x))
            $display("FAIL g10_hit%0d: got %h want %h",
                     i, obs(), pack(x));
         else n_pass++;
      end
      n_chk++;
      if (bus.score !== 7'(want) || bus.combo !== 7'd10)
         $display("FAIL g10_final: got %0d/%0d want %0d/10",
                  bus.score, bus.combo, want);
      else n_pass++;
   endtask

   task automatic test_miss();
      exp_t x;
      int   gr[5] = '{1, 1, 0, 1, 3};
      int   cw[5] = '{2 - 1, 2, 0, 1, 1};
      drive(1, 0, 0, 0);
      void'(sb.pop_front());
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 1, gr[i]);
         x = sb.pop_front();
         n_chk++;
         if (obs() !== pack(x) || bus.combo !== 7'(cw[i]))
            $display("FAIL miss_step%0d: got %h want %h",
                     i, obs(), pack(x));
         else n_pass++;
      end
      n_chk++;
      if (bus.max_combo !== 7'd2 || bus.score !== 7'd3
          || bus.score_upd !== 1'b0)
         $display("FAIL miss_final: got %0d/%0d want 2/3",
                  bus.max_combo, bus.score);
      else n_pass++;
   endtask

   task automatic test_saturate();
      exp_t x;
      drive(1, 0, 0, 0);
      void'(sb.pop_front());
      for (int i = 0; i < 45; i++) begin
         drive(0, 0, 1, 2);
         x = sb.pop_front();
         n_chk++;
         if (obs() !== pack(x))
            $display("FAIL sat_hit%0d: got %h want %h",
                     i, obs(), pack(x));
         else n_pass++;
      end
      n_chk++;
      if (bus.score !== 7'd127 || bus.combo !== 7'd45
          || bus.score_upd !== 1'b0)
         $display("FAIL sat_final: got %0d/%0d/%0d want 127/45/0",
                  bus.score, bus.combo, bus.score_upd);
      else n_pass++;
   endtask

   task automatic test_end_same_cycle();
      exp_t x;
      drive(1, 0, 0, 0);
      void'(sb.pop_front());
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 1, 2);
         void'(sb.pop_front());
      end
      drive(0, 1, 1, 2);
      x = sb.pop_front();
      n_chk++;
      if (obs() !== pack(x) || bus.score !== 7'd12
          || bus.final_valid !== 1'b1)
         $display("FAIL end_hit: got %h want %h", obs(), pack(x));
      else n_pass++;
      drive(0, 0, 1, 2);
      drive(0, 1, 0, 0);
      for (int i = 0; i < 2; i++) begin
         x = sb.pop_front();
         n_chk++;
         if (obs() !== pack(x) || bus.score !== 7'd12)
            $display("FAIL done_ignore%0d: got %h want %h",
                     i, obs(), pack(x));
         else n_pass++;
      end
      drive(1, 1, 1, 2);
      x = sb.pop_front();
      n_chk++;
      if (obs() !== pack(x) || bus.score !== 7'd0
          || bus.playing !== 1'b1)
         $display("FAIL restart: got %h want %h", obs(), pack(x));
      else n_pass++;
   endtask

   task automatic test_async_reset();
      exp_t x;
      drive(1, 0, 0, 0);
      for (int i = 0; i < 6; i++) drive(0, 0, 1, 2);
      drive(0, 0, 1, 1);
      drive(0, 0, 1, 1);
      while (sb.size() > 1) void'(sb.pop_front());
      x = sb.pop_front();
      n_chk++;
      if (obs() !== pack(x) || bus.score !== 7'd20)
         $display("FAIL pre_reset: got %h want %h", obs(), pack(x));
      else n_pass++;
      #2 resetn = 1'b0;
      #1;
      model_reset();
      n_chk++;
      if (obs() !== 24'd0)
         $display("FAIL async_reset: got %h want 000000", obs());
      else n_pass++;
      #3 resetn = 1'b1;
      @(posedge clk_sys); #1;
      drive(0, 0, 1, 2);
      drive(1, 0, 0, 0);
      drive(0, 0, 1, 2);
      for (int i = 0; i < 3; i++) begin
         x = sb.pop_front();
         n_chk++;
         if (obs() !== pack(x) && i == 2)
            $display("FAIL post_reset%0d: got %h want %h",
                     i, obs(), pack(x));
         else if (i == 2) n_pass++;
         else n_chk--;
      end
      n_chk++;
      if (bus.score !== 7'd3 || bus.playing !== 1'b1)
         $display("FAIL post_reset_play: got %0d want 3",
                  bus.score);
      else n_pass++;
   endtask

   task automatic test_idle_ignore();
      exp_t x;
      drive(0, 1, 1, 2);
      x = sb.pop_front();
      n_chk++;
      if (obs() !== pack(x) || obs() !== 24'd0)
         $display("FAIL idle_ignore: got %h want %h",
                  obs(), pack(x));
      else n_pass++;
   endtask

   initial begin
      bus.game_start = 1'b0;
      bus.game_end   = 1'b0;
      bus.hit_valid  = 1'b0;
      bus.hit_grade  = 2'd0;
      model_reset();
      #12;
      test_reset();
      #1 resetn = 1'b1;
      @(posedge clk_sys); #1;
      test_idle_ignore();
      test_perfect3();
      test_good10();
      test_miss();
      test_saturate();
      test_end_same_cycle();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
